// File: rtl/ela_row_if.sv
// Row-request bundle between the pixel source, the row server and the ELA engine.
// The slave side is the row server; the master side feeds pixels and issues requests.
interface ela_row_if;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       pix_ready;
    logic       req;
    logic [7:0] in_data;
    logic       row_avail;
    logic       frame_done;
    logic       err;

    modport master (
        output pix_in, pix_valid, req,
        input  pix_ready, in_data, row_avail, frame_done, err
    );

    modport slave (
        input  pix_in, pix_valid, req,
        output pix_ready, in_data, row_avail, frame_done, err
    );
endinterface

// File: rtl/ela_row_server.sv
// Decimating row server: keeps even rows of an incoming frame in two ping-pong
// row buffers and serves one buffered row per request as a gapless pixel burst.
module ela_row_server #(
    parameter int WIDTH    = 32,
    parameter int OUT_ROWS = 16
) (
    input  logic        clk,
    input  logic        rst,
    ela_row_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(2 * OUT_ROWS - 1);
    localparam int OW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

    localparam logic [CW-1:0] LAST_COL    = CW'(WIDTH - 1);
    localparam logic [RW-1:0] LAST_IN_ROW = RW'(2 * OUT_ROWS - 2);
    localparam logic [OW-1:0] LAST_OUT    = OW'(OUT_ROWS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   in_col_reg, in_col_next;
    logic [RW-1:0]   in_row_reg, in_row_next;
    logic            wr_buf_reg, wr_buf_next;
    logic [CW-1:0]   rd_col_reg, rd_col_next;
    logic            rd_buf_reg, rd_buf_next;
    logic [OW-1:0]   out_row_reg, out_row_next;
    logic [1:0]      full_reg, full_next;
    logic            frame_done_reg, frame_done_next;
    logic            err_reg, err_next;
    logic [7:0]      in_data_reg, in_data_next;
    logic            run_reg;

    logic            accept;
    logic            wr_fire;
    logic            wr_en;
    logic            row_done;
    logic            release_buf;
    logic            avail;

    logic [7:0]      mem [0:2*WIDTH-1];

    // Odd rows are always drained; even rows wait for a free buffer.
    assign accept   = run_reg && (in_row_reg[0] || !full_reg[wr_buf_reg]);
    assign wr_fire  = bus.pix_valid && accept;
    assign wr_en    = wr_fire && !in_row_reg[0];
    assign row_done = wr_en && (in_col_reg == LAST_COL);
    assign avail    = full_reg[rd_buf_reg] && (state_reg == IDLE);

    assign bus.pix_ready  = accept;
    assign bus.row_avail  = avail;
    assign bus.in_data    = in_data_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.err        = err_reg;

    always_comb begin
        in_col_next = in_col_reg;
        in_row_next = in_row_reg;
        wr_buf_next = wr_buf_reg;
        if (wr_fire) begin
            in_col_next = in_col_reg + 1'b1;
            if (in_col_reg == LAST_COL) begin
                in_col_next = '0;
                in_row_next = (in_row_reg == LAST_IN_ROW) ? '0 : in_row_reg + 1'b1;
                if (!in_row_reg[0]) begin
                    wr_buf_next = ~wr_buf_reg;
                end
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        rd_col_next     = rd_col_reg;
        rd_buf_next     = rd_buf_reg;
        out_row_next    = out_row_reg;
        frame_done_next = 1'b0;
        err_next        = err_reg;
        release_buf     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    if (avail) begin
                        state_next  = SEND;
                        rd_col_next = CW'(1);
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            SEND: begin
                if (bus.req) begin
                    err_next = 1'b1;
                end
                rd_col_next = rd_col_reg + 1'b1;
                if (rd_col_reg == LAST_COL) begin
                    release_buf     = 1'b1;
                    rd_col_next     = '0;
                    rd_buf_next     = ~rd_buf_reg;
                    state_next      = IDLE;
                    out_row_next    = (out_row_reg == LAST_OUT) ? '0 : out_row_reg + 1'b1;
                    frame_done_next = (out_row_reg == LAST_OUT);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Writer and reader always touch different buffers, so both updates can land together.
    always_comb begin
        full_next = full_reg;
        if (release_buf) begin
            full_next[rd_buf_reg] = 1'b0;
        end
        if (row_done) begin
            full_next[wr_buf_reg] = 1'b1;
        end
    end

    // Read one edge ahead so in_data is a plain register holding the pixel for the coming cycle.
    always_comb begin
        in_data_next = 8'd0;
        if (full_next[rd_buf_next]) begin
            in_data_next = mem[{rd_buf_next, rd_col_next}];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_buf_reg, in_col_reg}] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            in_col_reg     <= '0;
            in_row_reg     <= '0;
            wr_buf_reg     <= 1'b0;
            rd_col_reg     <= '0;
            rd_buf_reg     <= 1'b0;
            out_row_reg    <= '0;
            full_reg       <= 2'b00;
            frame_done_reg <= 1'b0;
            err_reg        <= 1'b0;
            in_data_reg    <= 8'd0;
            run_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            in_col_reg     <= in_col_next;
            in_row_reg     <= in_row_next;
            wr_buf_reg     <= wr_buf_next;
            rd_col_reg     <= rd_col_next;
            rd_buf_reg     <= rd_buf_next;
            out_row_reg    <= out_row_next;
            full_reg       <= full_next;
            frame_done_reg <= frame_done_next;
            err_reg        <= err_next;
            in_data_reg    <= in_data_next;
            run_reg        <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ela_row_server.sv
// Scoreboard bench for ela_row_server: a pixel producer and an ELA-style consumer
// step together each cycle; even-row pixels are queued on entry and checked on exit.
module tb_ela_row_server;
    localparam int W = 32;
    localparam int R = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ela_row_if bus ();

    ela_row_server #(.WIDTH(W), .OUT_ROWS(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    int pr_row, pr_col, pr_total, prod_limit;
    int serve_idx, rows_served, req_budget, glitch_at, fd_count;
    bit sync_row2, fd_exp, fd_set, err_exp;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) check_value({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        else check_value(tag, 32'(bus.in_data), 32'(exp_q.pop_front()));
    endtask

    task automatic reset_tb_state();
        exp_q.delete();
        pr_row = 0; pr_col = 0; pr_total = 0; prod_limit = 0;
        serve_idx = 0; rows_served = 0; req_budget = 0; glitch_at = -1;
        fd_count = 0; sync_row2 = 0; fd_exp = 0; fd_set = 0; err_exp = 0;
        bus.req = 1'b0; bus.pix_valid = 1'b0; bus.pix_in = 8'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        reset_tb_state();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: check frame_done, run the consumer, then the producer.
    task automatic tick();
        @(negedge clk);
        if (bus.frame_done || fd_exp) check_value("frame_done", 32'(bus.frame_done), 32'(fd_exp));
        if (bus.frame_done) fd_count++;
        fd_set  = 0;
        bus.req = 1'b0;
        if (serve_idx > 0) begin
            pop_check("pixel");
            if (serve_idx == glitch_at) begin
                check_value("err_before_glitch", 32'(bus.err), 32'(err_exp));
                bus.req = 1'b1;
                err_exp = 1;
            end
            serve_idx++;
            if (serve_idx == W) begin
                serve_idx = 0;
                rows_served++;
                $display("served row %0d (frame row %0d)", rows_served - 1, 2 * ((rows_served - 1) % R));
                if (rows_served % R == 0) fd_set = 1;
            end
        end else if (req_budget > 0 && bus.row_avail &&
                     (!sync_row2 || (pr_total < prod_limit && pr_row == 2 && pr_col == 0))) begin
            bus.req = 1'b1;
            pop_check("pixel");
            serve_idx = 1;
            req_budget--;
            sync_row2 = 0;
        end
        fd_exp = fd_set;
        if (pr_total < prod_limit) begin
            bus.pix_valid = 1'b1;
            bus.pix_in    = 8'((pr_row * 8 + pr_col) % 256);
            if (bus.pix_ready) begin
                if (pr_row % 2 == 0) exp_q.push_back(bus.pix_in);
                pr_col++;
                if (pr_col == W) begin
                    pr_col = 0;
                    pr_total++;
                    pr_row = (pr_row == 2 * R - 2) ? 0 : pr_row + 1;
                end
            end
        end else begin
            bus.pix_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_tb_state();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        check_value("rst_in_data", 32'(bus.in_data), 32'd0);
        check_value("rst_row_avail", 32'(bus.row_avail), 32'd0);
        check_value("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check_value("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        #1 check_value("ready_before_edge", 32'(bus.pix_ready), 32'd0);
        @(negedge clk);
        check_value("ready_after_edge", 32'(bus.pix_ready), 32'd1);

        // Full frame, consumer requests whenever a row is available.
        prod_limit = 2 * R - 1;
        req_budget = R;
        for (int c = 0; c < 4000 && rows_served < R; c++) tick();
        check_value("frame_rows", 32'(rows_served), 32'(R));
        repeat (2) tick();
        check_value("frame_done_count", 32'(fd_count), 32'd1);
        check_value("frame_err", 32'(bus.err), 32'(err_exp));
        check_value("frame_sb_empty", 32'(exp_q.size()), 32'd0);

        // Request with nothing buffered, then back-pressure with both buffers full.
        do_reset();
        @(negedge clk);
        check_value("idle_avail", 32'(bus.row_avail), 32'd0);
        check_value("idle_data", 32'(bus.in_data), 32'd0);
        bus.req = 1'b1;
        err_exp = 1;
        tick();
        check_value("idle_err", 32'(bus.err), 32'(err_exp));
        check_value("idle_data_after", 32'(bus.in_data), 32'd0);
        check_value("idle_avail_after", 32'(bus.row_avail), 32'd0);
        prod_limit = 5;
        for (int c = 0; c < 400 && pr_total < 4; c++) tick();
        repeat (4) tick();
        check_value("stall_ready", 32'(bus.pix_ready), 32'd0);
        check_value("stall_row", 32'(pr_total), 32'd4);
        check_value("stall_col", 32'(pr_col), 32'd0);
        req_budget = 1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (req_budget == 0 && serve_idx == 0) break;
        end
        check_value("bp_served", 32'(rows_served), 32'd1);
        check_value("ready_still_low", 32'(bus.pix_ready), 32'd0);
        tick();
        check_value("ready_back", 32'(bus.pix_ready), 32'd1);
        check_value("err_sticky", 32'(bus.err), 32'd1);

        // Release of buffer 0 coincides with row 2 completing into buffer 1; glitch req mid-row.
        do_reset();
        prod_limit = 5;
        req_budget = 1;
        sync_row2  = 1;
        glitch_at  = 10;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (req_budget == 0 && serve_idx == 0) break;
        end
        check_value("sync_served", 32'(rows_served), 32'd1);
        check_value("glitch_err", 32'(bus.err), 32'(err_exp));
        glitch_at  = -1;
        req_budget = 2;
        tick();
        check_value("sync_avail", 32'(bus.row_avail), 32'd1);
        check_value("sync_req_taken", 32'(serve_idx), 32'd1);
        for (int c = 0; c < 400 && !(rows_served == 3 && pr_total == 5); c++) tick();
        check_value("sync_rows", 32'(rows_served), 32'd3);
        check_value("sync_fed", 32'(pr_total), 32'd5);
        check_value("sync_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a served row.
        do_reset();
        prod_limit = 3;
        req_budget = 1;
        for (int c = 0; c < 200 && serve_idx != 18; c++) tick();
        check_value("mid_send_reached", 32'(serve_idx), 32'd18);
        #2 rst = 1'b1;
        #1;
        check_value("async_pix_ready", 32'(bus.pix_ready), 32'd0);
        check_value("async_in_data", 32'(bus.in_data), 32'd0);
        check_value("async_row_avail", 32'(bus.row_avail), 32'd0);
        check_value("async_frame_done", 32'(bus.frame_done), 32'd0);
        check_value("async_err", 32'(bus.err), 32'd0);
        reset_tb_state();
        @(negedge clk);
        rst = 1'b0;
        prod_limit = 3;
        req_budget = 2;
        for (int c = 0; c < 400 && rows_served < 2; c++) tick();
        check_value("restart_rows", 32'(rows_served), 32'd2);
        check_value("restart_sb_empty", 32'(exp_q.size()), 32'd0);
        check_value("restart_err", 32'(bus.err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ela_row_server.md
Name: ela_row_server

Overview:
- Source end of the ELA row-request interface. It accepts a full-resolution greyscale frame as a pixel stream and discards the odd rows.
- It buffers the even rows in two ping-pong row buffers. Each time the ELA engine raises req, it serves one buffered row of 32 pixels on in_data.
- It is the decimating counterpart to the ELA interpolator, which later reconstructs the odd rows.

Parameters:
- WIDTH, 32, pixels per row (power of 2).
- OUT_ROWS, 16, rows served per frame. The input frame is 2*OUT_ROWS-1 = 31 rows.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- pix_in  input  8  input pixel, raster order.
- pix_valid  input  1  pix_in valid this cycle.
- pix_ready  output  1  block can take pix_in this cycle. Transfer happens when pix_valid&&pix_ready.
- req  input  1  one-cycle row request from the ELA engine.
- in_data  output  8  served pixel.
- row_avail  output  1  at least one full even row is buffered and not yet served.
- frame_done  output  1  one-cycle pulse after the last pixel of served row OUT_ROWS-1.
- err  output  1  sticky flag: req arrived while no row was available, or while a row was already being served.

Behaviour:

Reset (async):
- Outputs: pix_ready=0, in_data=0, row_avail=0, frame_done=0, err=0.
- State: buffer-full flags cleared; in_row=0, in_col=0, wr_buf=0; rd_buf=0, rd_col=0, out_row=0; read FSM in IDLE.
- pix_ready rises on the first clock edge after rst deasserts.
- Reset mid-row abandons all buffered data.

Input side:
- in_col counts 0..WIDTH-1 on each transfer; in_row counts 0..2*OUT_ROWS-2.
- Odd in_row: pixels are accepted and discarded, and pix_ready=1 unconditionally.
- Even in_row: the pixel is written to buf[wr_buf][in_col]. pix_ready=1 only while full[wr_buf]=0.
- Row completion:
  - On the transfer with in_col=WIDTH-1 of an even row: set full[wr_buf], toggle wr_buf.
  - On in_col wrap: in_row increments; after row 2*OUT_ROWS-2 it wraps to 0 for the next frame.
- pix_ready is a registered-state function and does not depend on pix_valid.

Read FSM, states IDLE and SEND:
- row_avail = full[rd_buf] && state==IDLE.
- IDLE: in_data = buf[rd_buf][0] when full[rd_buf], else 0.
  - req=1 with row_avail=1: go to SEND, rd_col=1. Pixel 0 was sampled by the consumer on this edge.
  - req=1 with row_avail=0: set err; stay in IDLE.
- SEND: in_data = buf[rd_buf][rd_col]; rd_col increments every edge.
  - On the edge with rd_col=WIDTH-1: clear full[rd_buf], toggle rd_buf, rd_col=0, go to IDLE, out_row++.
  - When out_row wraps from OUT_ROWS-1 to 0, frame_done=1 for the next cycle.
  - req=1 during SEND sets err and is otherwise ignored.
- Consumer timing: pixel k is valid on the edge k cycles after the edge that sampled req, for k=0..WIDTH-1, i.e. 32 consecutive pixels with no gaps.
- in_data is driven from registers and buffer only; there is no combinational path from req.

Simultaneous events:
- The writer completing a row into buffer X and the reader releasing buffer Y on the same edge both take effect.
- The writer never targets a buffer whose full flag is set, so it cannot overwrite the row being served.
- Input writes continue during SEND into the other buffer.

err clears only on reset.

Test Plan:
- Reset then a frame of 31 rows, pixel = row*8+col mod 256, with a req issued whenever row_avail=1 → 16 rows served. Row r carries values (2r*8+col) mod 256, col 0..31, on consecutive edges; frame_done pulses once after the 512th served pixel.
- Feed rows 0–4 with no req → pix_ready drops at the start of row 4 (both buffers full, odd rows 1 and 3 discarded). After one req and 32 cycles, pix_ready returns to 1 the following cycle.
- req with nothing buffered → err=1, in_data=0, FSM stays IDLE. The next valid req still serves row 0 correctly.
- req pulsed again at rd_col=10 of SEND → err=1, and the served row continues unbroken to col 31.
- Reader releases buffer 0 on the same edge the writer completes row 2 into buffer 1 → both full flags correct; the next req serves row 2 data.
- Assert rst asynchronously mid-SEND at rd_col=17 → all outputs 0 immediately. After release, a new frame is served from row 0.
